// File: rtl/ws2812_frame_sched.sv
// Frame scheduler for the WS2812 strip: walks pixels through the color generator,
// hands GRB words to the serializer, then enforces latch gap and optional frame pacing.
module ws2812_frame_sched #(
    parameter int NUM_PIXELS   = 48,
    parameter int PX_W         = 6,
    parameter int LATCH_CYCLES = 8000,
    parameter int FRAME_PERIOD = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [23:0]     color_in,
    input  logic            tx_ready,
    input  logic            tx_busy,
    output logic [PX_W-1:0] px_num,
    output logic [7:0]      phase,
    output logic [23:0]     tx_data,
    output logic            tx_valid,
    output logic            frame_start,
    output logic            frame_done,
    output logic            busy
);

    localparam int LW = $clog2(LATCH_CYCLES + 1);
    localparam logic [PX_W-1:0] LAST_PX  = PX_W'(NUM_PIXELS - 1);
    localparam logic [LW-1:0]   LAST_LAT = LW'(LATCH_CYCLES - 1);
    localparam logic [31:0]     PACE_TC  = (FRAME_PERIOD == 0) ? 32'd0 : 32'(FRAME_PERIOD - 1);

    typedef enum logic [2:0] {IDLE, FETCH, SEND, DRAIN, LATCH, PACE} state_t;

    state_t          state_q, state_d;
    logic [PX_W-1:0] px_q, px_d;
    logic [7:0]      phase_q, phase_d;
    logic [23:0]     data_q, data_d;
    logic            valid_q, valid_d;
    logic            fstart_q, fstart_d;
    logic            fdone_q, fdone_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic [31:0]     fcnt_q, fcnt_d;
    logic            drain_wait_q, drain_wait_d;
    logic            pace_done;

    assign pace_done = (FRAME_PERIOD == 0) || (fcnt_q >= PACE_TC);

    always_comb begin
        state_d      = state_q;
        px_d         = px_q;
        phase_d      = phase_q;
        data_d       = data_q;
        valid_d      = valid_q;
        fstart_d     = 1'b0;
        fdone_d      = 1'b0;
        lat_d        = lat_q;
        drain_wait_d = drain_wait_q;
        fcnt_d       = (fcnt_q == 32'hFFFF_FFFF) ? fcnt_q : fcnt_q + 32'd1;

        case (state_q)
            IDLE: begin
                px_d   = '0;
                fcnt_d = '0;
                if (enable) begin
                    state_d  = FETCH;
                    fstart_d = 1'b1;
                end
            end
            FETCH: begin
                data_d  = color_in;
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (valid_q && tx_ready) begin
                    valid_d = 1'b0;
                    if (px_q == LAST_PX) begin
                        px_d         = '0;
                        drain_wait_d = 1'b1;
                        state_d      = DRAIN;
                    end else begin
                        px_d    = px_q + PX_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            DRAIN: begin
                // First DRAIN cycle is skipped: the serializer may raise busy one cycle late.
                drain_wait_d = 1'b0;
                if (!drain_wait_q && !tx_busy) begin
                    lat_d   = '0;
                    state_d = LATCH;
                end
            end
            LATCH: begin
                if (lat_q == LAST_LAT) begin
                    fdone_d = 1'b1;
                    phase_d = phase_q + 8'd1;
                    state_d = PACE;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            PACE: begin
                if (pace_done) begin
                    if (enable) begin
                        px_d     = '0;
                        fstart_d = 1'b1;
                        fcnt_d   = '0;
                        state_d  = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            px_q         <= '0;
            phase_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            fstart_q     <= 1'b0;
            fdone_q      <= 1'b0;
            lat_q        <= '0;
            fcnt_q       <= '0;
            drain_wait_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            px_q         <= px_d;
            phase_q      <= phase_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            fstart_q     <= fstart_d;
            fdone_q      <= fdone_d;
            lat_q        <= lat_d;
            fcnt_q       <= fcnt_d;
            drain_wait_q <= drain_wait_d;
        end
    end

    assign px_num      = px_q;
    assign phase       = phase_q;
    assign tx_data     = data_q;
    assign tx_valid    = valid_q;
    assign frame_start = fstart_q;
    assign frame_done  = fdone_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Directed bench for ws2812_frame_sched: one free-running instance (4 pixels, latch 10)
// plus two paced instances (period 200 and 20) sharing the clock and reset.
module tb_ws2812_frame_sched;

    localparam int NPX = 4;
    localparam int LAT = 10;
    localparam int PXW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic tx_ready = 1'b1;
    logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [PXW-1:0] px_a, px_b, px_c;
    logic [7:0]     phase_a, phase_b, phase_c;
    logic [23:0]    data_a, data_b, data_c;
    logic           tv_a, tv_b, tv_c, fs_a, fs_b, fs_c, fd_a, fd_b, fd_c, busy_a, busy_b, busy_c;
    logic [23:0]    col_a, col_b, col_c;
    logic           txb_a, txb_b, txb_c;
    int             bc_a = 0, bc_b = 0, bc_c = 0;

    assign col_a = {3{5'd0, px_a}};
    assign col_b = {3{5'd0, px_b}};
    assign col_c = {3{5'd0, px_c}};

    // Serializer model: busy for 3 cycles after each accept.
    always @(posedge clk) begin
        if (!rst_n) begin
            bc_a <= 0; bc_b <= 0; bc_c <= 0;
        end else begin
            bc_a <= (tv_a && tx_ready) ? 3 : (bc_a != 0 ? bc_a - 1 : 0);
            bc_b <= (tv_b && tx_ready) ? 3 : (bc_b != 0 ? bc_b - 1 : 0);
            bc_c <= (tv_c && tx_ready) ? 3 : (bc_c != 0 ? bc_c - 1 : 0);
        end
    end
    assign txb_a = (bc_a != 0);
    assign txb_b = (bc_b != 0);
    assign txb_c = (bc_c != 0);

    ws2812_frame_sched #(.NUM_PIXELS(NPX), .PX_W(PXW), .LATCH_CYCLES(LAT), .FRAME_PERIOD(0)) dut (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .color_in(col_a), .tx_ready(tx_ready),
        .tx_busy(txb_a), .px_num(px_a), .phase(phase_a), .tx_data(data_a), .tx_valid(tv_a),
        .frame_start(fs_a), .frame_done(fd_a), .busy(busy_a));

    ws2812_frame_sched #(.NUM_PIXELS(NPX), .PX_W(PXW), .LATCH_CYCLES(LAT), .FRAME_PERIOD(200)) dut_p200 (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .color_in(col_b), .tx_ready(tx_ready),
        .tx_busy(txb_b), .px_num(px_b), .phase(phase_b), .tx_data(data_b), .tx_valid(tv_b),
        .frame_start(fs_b), .frame_done(fd_b), .busy(busy_b));

    ws2812_frame_sched #(.NUM_PIXELS(NPX), .PX_W(PXW), .LATCH_CYCLES(LAT), .FRAME_PERIOD(20)) dut_p20 (
        .clk(clk), .rst_n(rst_n), .enable(en_c), .color_in(col_c), .tx_ready(tx_ready),
        .tx_busy(txb_c), .px_num(px_c), .phase(phase_c), .tx_data(data_c), .tx_valid(tv_c),
        .frame_start(fs_c), .frame_done(fd_c), .busy(busy_c));

    // Event log, sampled on the falling edge.
    logic [23:0] acc_d[$];
    int acc_c[$], fs_q[$], fd_q[$], bf_q[$], fsb_q[$], fsc_q[$];
    logic [7:0] ph_q[$];
    logic prev_txb = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (tv_a && tx_ready) begin acc_d.push_back(data_a); acc_c.push_back(cyc); end
            if (fs_a) fs_q.push_back(cyc);
            if (fd_a) begin fd_q.push_back(cyc); ph_q.push_back(phase_a); end
            if (prev_txb && !txb_a) bf_q.push_back(cyc);
            if (fs_b) fsb_q.push_back(cyc);
            if (fs_c) fsc_q.push_back(cyc);
        end
        prev_txb = txb_a;
    end

    int total = 0;
    int bad   = 0;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clear_log();
        acc_d.delete(); acc_c.delete(); fs_q.delete(); fd_q.delete();
        bf_q.delete(); ph_q.delete(); fsb_q.delete(); fsc_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; tx_ready = 1'b1;
        step(); step();
        rst_n = 1'b1;
        step();
        clear_log();
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step();
            if (!busy_a) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if ({px_a, phase_a, data_a, tv_a, fs_a, fd_a, busy_a} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: px=%0d phase=%0d data=%h valid=%b fs=%b fd=%b busy=%b, required all zero",
                     px_a, phase_a, data_a, tv_a, fs_a, fd_a, busy_a);
        end
        do_reset();
        total++;
        if (busy_a !== 1'b0 || tv_a !== 1'b0) begin
            bad++; $display("FAIL reset_idle: busy=%b valid=%b, required 0 0", busy_a, tv_a);
        end
    endtask

    task automatic test_basic();
        int en_cyc;
        bit ok;
        logic [23:0] exp;
        do_reset();
        en_a = 1'b1; en_cyc = cyc;
        step();
        en_a = 1'b0;
        wait_idle(200, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_timeout: busy still %b, required 0", busy_a); end
        total++;
        if (fs_q.size() != 1 || fs_q[0] != en_cyc + 1) begin
            bad++; $display("FAIL basic_frame_start: count=%0d cyc=%0d, required 1 at %0d",
                            fs_q.size(), fs_q.size() ? fs_q[0] : -1, en_cyc + 1);
        end
        total++;
        if (acc_c.size() == 0 || acc_c[0] != en_cyc + 2) begin
            bad++; $display("FAIL basic_first_valid: cyc=%0d, required %0d",
                            acc_c.size() ? acc_c[0] : -1, en_cyc + 2);
        end
        total++;
        if (acc_d.size() != NPX) begin
            bad++; $display("FAIL basic_word_count: got %0d, required %0d", acc_d.size(), NPX);
        end else begin
            for (int k = 0; k < NPX; k++) begin
                exp = 24'h010101 * k;
                total++;
                if (acc_d[k] !== exp) begin
                    bad++; $display("FAIL basic_word%0d: got %h, required %h", k, acc_d[k], exp);
                end
            end
            total++;
            if (acc_c[NPX-1] - acc_c[0] != 2 * (NPX - 1)) begin
                bad++; $display("FAIL basic_pixel_rate: span=%0d, required %0d",
                                acc_c[NPX-1] - acc_c[0], 2 * (NPX - 1));
            end
        end
        // One cycle to observe busy low in DRAIN, then LAT cycles in LATCH.
        total++;
        if (fd_q.size() != 1 || bf_q.size() == 0 || fd_q[0] - bf_q[bf_q.size()-1] != LAT + 1) begin
            bad++; $display("FAIL basic_latch_gap: fd_count=%0d gap=%0d, required 1 and %0d", fd_q.size(),
                            (fd_q.size() && bf_q.size()) ? fd_q[0] - bf_q[bf_q.size()-1] : -1, LAT + 1);
        end
        total++;
        if (fd_q.size() != 1 || fd_q[0] != en_cyc + 23) begin
            bad++; $display("FAIL basic_frame_done_cyc: got %0d, required %0d",
                            fd_q.size() ? fd_q[0] : -1, en_cyc + 23);
        end
        total++;
        if (ph_q.size() != 1 || ph_q[0] !== 8'd1 || phase_a !== 8'd1) begin
            bad++; $display("FAIL basic_phase: at_done=%0d now=%0d, required 1",
                            ph_q.size() ? ph_q[0] : 8'hff, phase_a);
        end
    endtask

    task automatic test_stall();
        bit ok;
        do_reset();
        en_a = 1'b1;
        step();
        en_a = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (px_a == 3'd2 && tv_a) begin ok = 1'b1; break; end
            step();
        end
        total++;
        if (!ok) begin bad++; $display("FAIL stall_reach_px2: px=%0d valid=%b, required 2 1", px_a, tv_a); end
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (tv_a !== 1'b1 || data_a !== 24'h020202 || acc_d.size() != 2) begin
                bad++; $display("FAIL stall_hold%0d: valid=%b data=%h accepts=%0d, required 1 020202 2",
                                i, tv_a, data_a, acc_d.size());
            end
            step();
        end
        tx_ready = 1'b1;
        wait_idle(200, ok);
        total++;
        if (!ok || acc_d.size() != NPX || acc_d[0] !== 24'h0 || acc_d[1] !== 24'h010101 ||
            acc_d[2] !== 24'h020202 || acc_d[3] !== 24'h030303) begin
            bad++; $display("FAIL stall_sequence: idle=%b accepts=%0d, required 1 and 00/01/02/03 words",
                            ok, acc_d.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int errs;
        do_reset();
        en_a = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 260 * 30; i++) begin
            step();
            if (fd_q.size() >= 260) begin ok = 1'b1; break; end
        end
        en_a = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL wrap_timeout: frames=%0d, required 260", fd_q.size()); end
        wait_idle(200, ok);
        total++;
        if (!ok || fd_q.size() != 261 || fs_q.size() != 261) begin
            bad++; $display("FAIL wrap_counts: idle=%b starts=%0d dones=%0d, required 1 261 261",
                            ok, fs_q.size(), fd_q.size());
        end
        if (ph_q.size() >= 256) begin
            total++;
            if (ph_q[254] !== 8'd255 || ph_q[255] !== 8'd0) begin
                bad++; $display("FAIL wrap_phase: frame255=%0d frame256=%0d, required 255 0",
                                ph_q[254], ph_q[255]);
            end
        end
        errs = 0;
        for (int k = 0; k < ph_q.size(); k++)
            if (ph_q[k] !== 8'((k + 1) % 256)) errs++;
        for (int k = 1; k < fs_q.size(); k++)
            if (fs_q[k] - fs_q[k-1] != 23) errs++;
        total++;
        if (errs != 0) begin bad++; $display("FAIL wrap_phase_spacing: errors=%0d, required 0", errs); end
    endtask

    task automatic test_pace();
        int errs;
        do_reset();
        en_b = 1'b1; en_c = 1'b1;
        repeat (700) step();
        en_b = 1'b0; en_c = 1'b0;
        repeat (250) step();
        total++;
        if (fsb_q.size() != 4) begin
            bad++; $display("FAIL pace200_count: got %0d, required 4", fsb_q.size());
        end else begin
            errs = 0;
            for (int k = 1; k < 4; k++) if (fsb_q[k] - fsb_q[k-1] != 200) errs++;
            total++;
            if (errs != 0) begin
                bad++; $display("FAIL pace200_spacing: first gap=%0d, required 200", fsb_q[1] - fsb_q[0]);
            end
        end
        errs = 0;
        for (int k = 1; k < fsc_q.size(); k++) if (fsc_q[k] - fsc_q[k-1] != 23) errs++;
        total++;
        if (fsc_q.size() < 20 || errs != 0) begin
            bad++; $display("FAIL pace20_spacing: starts=%0d bad_gaps=%0d, required >=20 and 0 (gap 23)",
                            fsc_q.size(), errs);
        end
        total++;
        if (busy_b !== 1'b0 || busy_c !== 1'b0) begin
            bad++; $display("FAIL pace_idle: busy_b=%b busy_c=%b, required 0 0", busy_b, busy_c);
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        do_reset();
        en_a = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (px_a == 3'd1) begin ok = 1'b1; break; end
        end
        en_a = 1'b0;
        wait_idle(200, ok);
        repeat (30) step();
        total++;
        if (!ok || acc_d.size() != NPX || fd_q.size() != 1 || fs_q.size() != 1) begin
            bad++; $display("FAIL drop_frame: idle=%b words=%0d dones=%0d starts=%0d, required 1 4 1 1",
                            ok, acc_d.size(), fd_q.size(), fs_q.size());
        end
        total++;
        if (phase_a !== 8'd1 || busy_a !== 1'b0) begin
            bad++; $display("FAIL drop_state: phase=%0d busy=%b, required 1 0", phase_a, busy_a);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        en_a = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (px_a == 3'd2 && tv_a) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok || phase_a !== 8'd1) begin
            bad++; $display("FAIL rstmid_setup: reached=%b phase=%0d, required 1 1", ok, phase_a);
        end
        tx_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (tv_a !== 1'b0 || px_a !== '0 || phase_a !== 8'd0 || data_a !== 24'h0 || busy_a !== 1'b0) begin
            bad++; $display("FAIL rstmid_async: valid=%b px=%0d phase=%0d data=%h busy=%b, required all zero",
                            tv_a, px_a, phase_a, data_a, busy_a);
        end
        clear_log();
        tx_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        en_a = 1'b0;
        wait_idle(200, ok);
        total++;
        if (!ok || acc_d.size() != NPX || acc_d[0] !== 24'h0 || acc_d[3] !== 24'h030303 ||
            phase_a !== 8'd1 || fs_q.size() != 1) begin
            bad++; $display("FAIL rstmid_restart: idle=%b words=%0d phase=%0d starts=%0d, required 1 4 1 1",
                            ok, acc_d.size(), phase_a, fs_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_pace();
        test_enable_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
